// File: rtl/core_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : core_ctrl_if
// Description : Handshake/instruction bundle between core_ctrl and the core.
//               cycle_cnt exists only when CORE_CTRL_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface core_ctrl_if;
    logic        start;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        busy;
    logic        done;
`ifdef CORE_CTRL_PERF_EN
    logic [31:0] cycle_cnt;

    modport master (output start, ofifo_valid, input inst, busy, done, cycle_cnt);
    modport slave  (input start, ofifo_valid, output inst, busy, done, cycle_cnt);
`else
    modport master (output start, ofifo_valid, input inst, busy, done);
    modport slave  (input start, ofifo_valid, output inst, busy, done);
`endif
endinterface
`default_nettype wire

// File: rtl/core_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : core_ctrl
// Description : Sequences weight load, activation execute and psum drain for
//               every kernel position; CORE_CTRL_PERF_EN adds a busy counter.
// Revision    : 1.0 - initial release
// ============================================================================
module core_ctrl #(
    parameter int          ROW     = 8,
    parameter int          COL     = 8,
    parameter int          LEN_KIJ = 9,
    parameter int          LEN_NIJ = 36,
    parameter logic [10:0] W_BASE  = 11'd1024,
    parameter logic [10:0] P_BASE  = 11'd0
) (
    input  wire logic  clk,
    input  wire logic  reset,
    core_ctrl_if.slave bus
);
    localparam logic [33:0] c_idle_word = 34'h1_800C_0000;
    localparam logic [15:0] c_col       = 16'(COL);
    localparam logic [15:0] c_wait      = 16'(ROW + COL);
    localparam logic [15:0] c_nij       = 16'(LEN_NIJ);
    localparam logic [15:0] c_kij       = 16'(LEN_KIJ);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_W_RD   = 4'd1,
        S_W_LD   = 4'd2,
        S_W_WAIT = 4'd3,
        S_X_RD   = 4'd4,
        S_X_EX   = 4'd5,
        S_DRAIN  = 4'd6,
        S_NEXT   = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_kij, w_kij_nxt;
    logic [15:0] r_t, w_t_nxt;
    logic [15:0] r_pops, w_pops_nxt;
    logic [15:0] r_wrs, w_wrs_nxt;
    logic [33:0] r_inst, w_inst;
    logic        r_busy;
    logic        r_done;

    always_comb begin
        w_state_nxt = r_state;
        w_kij_nxt   = r_kij;
        w_t_nxt     = r_t + 16'd1;
        w_pops_nxt  = r_pops;
        w_wrs_nxt   = r_wrs;
        w_inst      = c_idle_word;

        // Whatever xmem returned for last cycle's read is captured into L0 now.
        w_inst[2] = ~r_inst[19];

        // A pop made visible last cycle turns into a pmem write this cycle.
        if (r_inst[6]) begin
            w_inst[33]    = (r_kij != 16'd0);
            w_inst[32]    = 1'b0;
            w_inst[31]    = 1'b0;
            w_inst[30:20] = P_BASE + r_wrs[10:0];
            w_wrs_nxt     = r_wrs + 16'd1;
        end

        if ((r_state == S_X_EX || r_state == S_DRAIN) && bus.ofifo_valid && (r_pops < c_nij)) begin
            w_inst[6]  = 1'b1;
            w_pops_nxt = r_pops + 16'd1;
        end

        case (r_state)
            S_IDLE: begin
                w_t_nxt = '0;
                if (bus.start) begin
                    w_state_nxt = S_W_RD;
                    w_kij_nxt   = '0;
                    w_pops_nxt  = '0;
                    w_wrs_nxt   = '0;
                end
            end
            S_W_RD: begin
                if (r_t < c_col) begin
                    w_inst[19]   = 1'b0;
                    w_inst[17:7] = W_BASE + 11'(r_kij * c_col) + r_t[10:0];
                end else begin
                    w_state_nxt = S_W_LD;
                    w_t_nxt     = '0;
                end
            end
            S_W_LD: begin
                w_inst[3] = 1'b1;
                w_inst[0] = 1'b1;
                if (r_t == c_col - 16'd1) begin
                    w_state_nxt = S_W_WAIT;
                    w_t_nxt     = '0;
                end
            end
            S_W_WAIT: begin
                if (r_t == c_wait - 16'd1) begin
                    w_state_nxt = S_X_RD;
                    w_t_nxt     = '0;
                end
            end
            S_X_RD: begin
                if (r_t < c_nij) begin
                    w_inst[19]   = 1'b0;
                    w_inst[17:7] = r_t[10:0];
                end else begin
                    w_state_nxt = S_X_EX;
                    w_t_nxt     = '0;
                end
            end
            S_X_EX: begin
                w_inst[3] = 1'b1;
                w_inst[1] = 1'b1;
                if (r_t == c_nij - 16'd1) begin
                    w_state_nxt = S_DRAIN;
                    w_t_nxt     = '0;
                end
            end
            S_DRAIN: begin
                if (r_wrs == c_nij) begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                w_t_nxt    = '0;
                w_pops_nxt = '0;
                w_wrs_nxt  = '0;
                if (r_kij == c_kij - 16'd1) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_kij_nxt   = r_kij + 16'd1;
                    w_state_nxt = S_W_RD;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_kij   <= '0;
            r_t     <= '0;
            r_pops  <= '0;
            r_wrs   <= '0;
            r_inst  <= c_idle_word;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_kij   <= w_kij_nxt;
            r_t     <= w_t_nxt;
            r_pops  <= w_pops_nxt;
            r_wrs   <= w_wrs_nxt;
            r_inst  <= w_inst;
            r_busy  <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    assign bus.inst = r_inst;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

`ifdef CORE_CTRL_PERF_EN
    logic [31:0] r_cycle_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle_cnt <= '0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_cycle_cnt <= '0;
        end else if (r_busy) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    assign bus.cycle_cnt = r_cycle_cnt;
`endif
endmodule
`default_nettype wire

// File: tb/tb_core_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_ctrl
// Description : Scoreboard bench for core_ctrl with randomized ofifo_valid;
//               also covers cycle_cnt when CORE_CTRL_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_ctrl;
    localparam int          ROW     = 8;
    localparam int          COL     = 8;
    localparam int          LEN_KIJ = 9;
    localparam int          LEN_NIJ = 36;
    localparam logic [10:0] W_BASE  = 11'd1024;
    localparam logic [10:0] P_BASE  = 11'd0;
    localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    core_ctrl_if bus ();

    core_ctrl #(
        .ROW     (ROW),
        .COL     (COL),
        .LEN_KIJ (LEN_KIJ),
        .LEN_NIJ (LEN_NIJ),
        .W_BASE  (W_BASE),
        .P_BASE  (P_BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected responses, filled when a run is started.
    logic [10:0] q_xaddr[$];
    logic [11:0] q_pw[$];
    int          q_done[$];

    int vmode = 0;
    bit mon_en = 0;
    bit got_done = 0;

    logic [33:0] m_ins;
    int cyc, last_load_cyc, last_wr_cyc;
    int ld_run, ex_run, ld_runs, writes_run, busy_cyc, final_cnt;
    bit prev_rd, prev_pop, prev_valid, prev_start, prev_busy, prev_done;
    bit gap_pending, ex_seen, have_final;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic mon_reset();
        cyc = 0; last_load_cyc = 0; last_wr_cyc = 0;
        ld_run = 0; ex_run = 0; ld_runs = 0; writes_run = 0; busy_cyc = 0; final_cnt = 0;
        prev_rd = 0; prev_pop = 0; prev_valid = 0; prev_start = 0; prev_busy = 0; prev_done = 0;
        gap_pending = 0; ex_seen = 0; have_final = 0;
    endtask

    // Reference model: the full address/write trace of one run.
    task automatic push_run();
        for (int k = 0; k < LEN_KIJ; k++) begin
            for (int t = 0; t < COL; t++) q_xaddr.push_back(11'(int'(W_BASE) + k * COL + t));
            for (int t = 0; t < LEN_NIJ; t++) q_xaddr.push_back(11'(t));
            for (int i = 0; i < LEN_NIJ; i++) q_pw.push_back({(k != 0), 11'(int'(P_BASE) + i)});
        end
        q_done.push_back(LEN_KIJ * LEN_NIJ);
    endtask

    // ofifo_valid pattern generator: 0 held high, 1 toggling, 2 coin flip, 3 mostly high.
    initial begin
        bus.ofifo_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (vmode)
                0:       bus.ofifo_valid = 1'b1;
                1:       bus.ofifo_valid = ~bus.ofifo_valid;
                2:       bus.ofifo_valid = 1'($urandom_range(0, 1));
                default: bus.ofifo_valid = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: compares every visible instruction against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            m_ins = bus.inst;
            cyc++;
            if (prev_start && !prev_busy && !prev_done) begin
                chk("busy_after_start", bus.busy, 1);
                writes_run = 0; busy_cyc = 0; have_final = 0; ld_runs = 0;
            end
            if (bus.busy) busy_cyc++;
            chk("ififo_zero", m_ins[5:4], 0);
            chk("l0_wr_lag", m_ins[2], prev_rd);
            chk("l0_rd_match", m_ins[3], m_ins[0] | m_ins[1]);
            chk("l0_wr_load_overlap", m_ins[2] & (m_ins[0] | m_ins[1]), 0);
            chk("pmem_after_pop", !m_ins[32], prev_pop);
            if (!bus.busy) chk("idle_word", m_ins, IDLE_WORD);

            if (m_ins[0]) begin
                if (ld_run == 0) begin ld_runs++; ex_seen = 0; end
                ld_run++;
            end else if (ld_run != 0) begin
                chk("load_len", ld_run, COL);
                ld_run = 0; gap_pending = 1; last_load_cyc = cyc - 1;
            end
            if (m_ins[1]) begin
                ex_seen = 1; ex_run++;
            end else if (ex_run != 0) begin
                chk("exec_len", ex_run, LEN_NIJ);
                ex_run = 0;
            end
            if (m_ins[6]) begin
                chk("pop_in_window", ex_seen, 1);
                chk("pop_on_valid", prev_valid, 1);
            end

            if (!m_ins[19]) begin
                chk("xmem_read_not_write", m_ins[18], 1);
                chk("xmem_expected", q_xaddr.size() > 0, 1);
                if (q_xaddr.size() > 0) chk("A_xmem", m_ins[17:7], q_xaddr.pop_front());
                if (gap_pending) begin
                    chk("weight_settle_gap", cyc - last_load_cyc, ROW + COL + 1);
                    gap_pending = 0;
                end
            end

            if (!m_ins[32]) begin
                chk("pmem_write_en", m_ins[31], 0);
                chk("pmem_expected", q_pw.size() > 0, 1);
                if (q_pw.size() > 0) chk("pmem_acc_addr", {m_ins[33], m_ins[30:20]}, q_pw.pop_front());
                writes_run++;
                last_wr_cyc = cyc;
            end

            if (bus.done) begin
                chk("done_single", prev_done, 0);
                chk("done_not_busy", bus.busy, 0);
                chk("done_expected", q_done.size() > 0, 1);
                if (q_done.size() > 0) chk("writes_at_done", writes_run, q_done.pop_front());
                chk("done_after_last_write", (cyc - last_wr_cyc >= 1) && (cyc - last_wr_cyc <= 3), 1);
`ifdef CORE_CTRL_PERF_EN
                chk("cycle_cnt_at_done", bus.cycle_cnt, busy_cyc);
                final_cnt = busy_cyc;
                have_final = 1;
`endif
                got_done = 1;
            end
`ifdef CORE_CTRL_PERF_EN
            else if (have_final && !bus.busy) begin
                chk("cycle_cnt_frozen", bus.cycle_cnt, final_cnt);
            end
`endif

            prev_rd    = !m_ins[19];
            prev_pop   = m_ins[6];
            prev_valid = bus.ofifo_valid;
            prev_start = bus.start;
            prev_busy  = bus.busy;
            prev_done  = bus.done;
        end
    end

    task automatic do_abort();
        reset = 1'b0;
        mon_en = 0;
        bus.start = 1'b0;
        #1;
        chk("reset_idle_word", bus.inst, IDLE_WORD);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        q_xaddr.delete();
        q_pw.delete();
        q_done.delete();
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        mon_reset();
        mon_en = 1;
    endtask

    task automatic do_run(input int mode, input bit abort);
        bit aborted;
        aborted = 0;
        vmode = mode;
        got_done = 0;
        @(posedge clk);
        #1 bus.start = 1'b1;
        push_run();
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            @(posedge clk);
            #1;
            bus.start = (mode == 1) && bus.busy && ($urandom_range(0, 40) == 0);
            if (abort && ld_runs >= 5 && bus.inst[1]) begin
                do_abort();
                aborted = 1;
                break;
            end
            if (got_done) break;
        end
        bus.start = 1'b0;
        if (!aborted) chk("run_completes", got_done, 1);
        repeat (8) @(posedge clk);
    endtask

    initial begin
        bus.start = 1'b0;
        mon_reset();
        #1 reset = 1'b0;
        #1;
        chk("por_idle_word", bus.inst, IDLE_WORD);
        chk("por_busy", bus.busy, 0);
        chk("por_done", bus.done, 0);
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        mon_en = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("boot_idle_word", bus.inst, IDLE_WORD);
            chk("boot_busy", bus.busy, 0);
            chk("boot_done", bus.done, 0);
`ifdef CORE_CTRL_PERF_EN
            chk("boot_cycle_cnt", bus.cycle_cnt, 0);
`endif
        end

        do_run(0, 0);
        do_run(1, 0);
        do_run(2, 0);
        do_run(2, 1);
        repeat (6) @(posedge clk);
        do_run(3, 0);

        chk("xmem_queue_drained", q_xaddr.size(), 0);
        chk("pmem_queue_drained", q_pw.size(), 0);
        chk("done_queue_drained", q_done.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/core_ctrl.md
CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 Parameter row, default 8, PE rows of the array.
REQ-002 Parameter col, default 8, PE columns; also weight words per kij.
REQ-003 Parameter len_kij, default 9, kernel positions per run.
REQ-004 Parameter len_nij, default 36, activation words in xmem, starting at address 0.
REQ-005 Parameter W_BASE, default 11'd1024, xmem address of weight word 0 of kij 0.
REQ-006 Parameter P_BASE, default 11'd0, pmem base address for psums.
REQ-007 Reset is asynchronous and active-low; there is one clock.
REQ-008 clk  input  1  clock, all state on rising edge.
REQ-009 reset  input  1  asynchronous active-low reset.
REQ-010 start  input  1  one-cycle pulse, begins a run when IDLE.
REQ-011 ofifo_valid  input  1  core output FIFO holds a full row of psums.
REQ-012 inst  output  34  core instruction word, registered: [33]acc [32]CEN_pmem [31]WEN_pmem [30:20]A_pmem [19]CEN_xmem [18]WEN_xmem [17:7]A_xmem [6]ofifo_rd [5]ififo_wr [4]ififo_rd [3]l0_rd [2]l0_wr [1]execute [0]load.
REQ-013 busy  output  1  high from the cycle after start is accepted until done.
REQ-014 done  output  1  one-cycle pulse after the last pmem write of kij len_kij-1.

Function
REQ-015 States: IDLE, W_RD, W_LD, W_WAIT, X_RD, X_EX, DRAIN, NEXT, DONE; kij counter 0..len_kij-1.
REQ-016 IDLE: inst holds the idle word 34'h1_800C_0000 (both CEN=1, both WEN=1, everything else 0); start -> W_RD, kij=0.
REQ-017 W_RD, col cycles: CEN_xmem=0, WEN_xmem=1, A_xmem=W_BASE+kij*col+t; l0_wr asserted for col cycles, lagging by exactly one cycle (one-cycle SRAM read latency).
REQ-018 W_LD, col cycles, entered after the last l0_wr: l0_rd=1, load=1.
REQ-019 W_WAIT, row+col cycles, idle word, so the weights settle in the array.
REQ-020 X_RD, len_nij cycles: xmem read A_xmem=t (0..len_nij-1); l0_wr lagging by one cycle as in W_RD.
REQ-021 X_EX, len_nij cycles, entered after the last l0_wr: l0_rd=1, execute=1.
REQ-022 DRAIN: ofifo_rd=1 in any cycle with ofifo_valid=1 and pops<len_nij; the cycle after each pop, pmem write: CEN_pmem=0, WEN_pmem=0, A_pmem=P_BASE+pop index, acc=(kij!=0).
REQ-023 DRAIN also accepts ofifo_valid during X_EX (pops may overlap execution); a pop and a pmem write in the same cycle are legal.
REQ-024 After len_nij pmem writes -> NEXT: kij<len_kij-1 -> kij+1, W_RD; else DONE.
REQ-025 DONE: done=1 for one cycle, busy=0, -> IDLE.
REQ-026 start while busy is ignored; ofifo_valid outside X_EX/DRAIN is ignored (no pop).
REQ-027 ififo_wr and ififo_rd are always 0.
REQ-028 Address fields wrap modulo 2^11; the block does not range-check them.

Reset
REQ-029 reset low forces IDLE, kij=0, all counters 0, inst=idle word, busy=0, done=0, immediately and including mid-run; no partial write completes after release.
REQ-030 After reset rises, the block waits in IDLE for a new start.

Configuration
REQ-031 Macro CORE_CTRL_PERF_EN defined: adds output cycle_cnt[31:0], cleared on an accepted start, +1 each busy cycle, frozen at done, 0 on reset; undefined: the port and counter are absent and the behaviour is otherwise identical.

Verification
REQ-032 Reset at cycle 0, no start for 20 cycles -> inst=34'h1_800C_0000, busy=0, done=0 throughout.
REQ-033 start, kij 0 -> A_xmem 1024..1031 with CEN_xmem=0, l0_wr high 8 cycles one cycle later, then 8 cycles load=1/l0_rd=1, then 16 idle cycles.
REQ-034 ofifo_valid held high -> 36 pops, pmem writes at A_pmem 0..35 with acc=0 for kij 0 and acc=1 for kij 1..8; one done pulse after 324 writes in total.
REQ-035 ofifo_valid toggling 1/0 during DRAIN -> pops only on high cycles, exactly 36 writes per kij, in order.
REQ-036 reset asserted in kij 4 X_EX -> idle word on the same edge; next start restarts at kij 0, A_xmem 1024.
REQ-037 With CORE_CTRL_PERF_EN and ofifo_valid tied high -> cycle_cnt at done equals the measured busy-cycle count and stays frozen until the next start.
